// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR scrub controller.
// State encoding, replica indices and a 3-bit popcount.
package tmr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCRUB,
    CHECK,
    FAULT
  } state_t;

  localparam int unsigned R0 = 0;
  localparam int unsigned R1 = 1;
  localparam int unsigned R2 = 2;

  function automatic logic [1:0] popcount3(
    input logic [2:0] m
  );
    return {1'b0, m[0]} + {1'b0, m[1]} + {1'b0, m[2]};
  endfunction

endpackage

// File: rtl/tmr_vote3.sv
// Bitwise majority voter over three replicas.
// Also reports which replicas disagree with the vote.
module tmr_vote3
  import tmr_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [W-1:0] C,
  output logic [W-1:0] V,
  output logic [2:0]   mask,
  output logic         multi
);

  assign V = (A & B) | (A & C) | (B & C);

  assign mask[R0] = |(A ^ V);
  assign mask[R1] = |(B ^ V);
  assign mask[R2] = |(C ^ V);

  assign multi = (popcount3(mask) >= 2'd2);

endmodule

// File: rtl/tmr_scrub_ctrl.sv
// TMR controller: votes, detects, scrubs single upsets.
// Declares a sticky hard fault when scrubbing cannot recover.
module tmr_scrub_ctrl
  import tmr_pkg::*;
#(
  parameter int W       = 32,
  parameter int CNT_W   = 8,
  parameter int PERSIST = 3
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             EN,
  input  logic             WR_CE,
  input  logic [W-1:0]     WR_DI,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  input  logic             CLR,
  output logic [2:0]       CE_OUT,
  output logic [W-1:0]     DI_OUT,
  output logic [W-1:0]     DO,
  output logic             ERR_SINGLE,
  output logic             ERR_MULTI,
  output logic             HARD_FAULT,
  output logic [2:0]       FAULT_MASK,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam logic [3:0] PERSIST_L = 4'(PERSIST);

  logic [W-1:0] v;
  logic [2:0]   mask;
  logic         multi;

  tmr_vote3 #(.W(W)) u_vote (
    .A     (A),
    .B     (B),
    .C     (C),
    .V     (v),
    .mask  (mask),
    .multi (multi)
  );

  state_t         state_q, state_d;
  logic [3:0]     retry_q, retry_d;
  logic [W-1:0]   scrub_q, scrub_d;
  logic [2:0]     mask_q, mask_d;
  logic [W-1:0]   do_q, do_d;
  logic           err_single_q, err_single_d;
  logic           err_multi_q, err_multi_d;
  logic           hard_fault_q, hard_fault_d;
  logic [2:0]     fault_mask_q, fault_mask_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic       det;
  logic       cnt_inc;
  logic [3:0] retry_inc;

  assign det       = EN & ~WR_CE;
  assign retry_inc = retry_q + 4'd1;

  // Next-state: detection, scrub/check rounds, fault entry, clear.
  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    scrub_d      = scrub_q;
    mask_d       = mask_q;
    do_d         = v;
    err_single_d = 1'b0;
    err_multi_d  = 1'b0;
    hard_fault_d = hard_fault_q;
    fault_mask_d = fault_mask_q;
    err_cnt_d    = err_cnt_q;
    cnt_inc      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (det && multi) begin
          err_multi_d  = 1'b1;
          cnt_inc      = 1'b1;
          fault_mask_d = mask;
          hard_fault_d = 1'b1;
          state_d      = FAULT;
        end else if (det && (mask != 3'b000)) begin
          scrub_d      = v;
          mask_d       = mask;
          err_single_d = 1'b1;
          cnt_inc      = 1'b1;
          state_d      = SCRUB;
        end
      end
      SCRUB: begin
        if (WR_CE) begin
          retry_d = 4'd0;
          state_d = IDLE;
        end else begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (WR_CE || (mask == 3'b000)) begin
          retry_d = 4'd0;
          state_d = IDLE;
        end else if (retry_inc == PERSIST_L) begin
          retry_d      = retry_inc;
          fault_mask_d = mask_q;
          hard_fault_d = 1'b1;
          state_d      = FAULT;
        end else begin
          retry_d = retry_inc;
          state_d = SCRUB;
        end
      end
      FAULT: begin
        hard_fault_d = 1'b1;
      end
    endcase
    if (cnt_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    if (CLR) begin
      state_d      = IDLE;
      retry_d      = 4'd0;
      hard_fault_d = 1'b0;
      fault_mask_d = 3'b000;
      err_cnt_d    = '0;
      err_single_d = 1'b0;
      err_multi_d  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      retry_q      <= 4'd0;
      scrub_q      <= '0;
      mask_q       <= 3'b000;
      do_q         <= '0;
      err_single_q <= 1'b0;
      err_multi_q  <= 1'b0;
      hard_fault_q <= 1'b0;
      fault_mask_q <= 3'b000;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      scrub_q      <= scrub_d;
      mask_q       <= mask_d;
      do_q         <= do_d;
      err_single_q <= err_single_d;
      err_multi_q  <= err_multi_d;
      hard_fault_q <= hard_fault_d;
      fault_mask_q <= fault_mask_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign CE_OUT = WR_CE ? 3'b111 :
                  (state_q == SCRUB) ? mask_q : 3'b000;
  assign DI_OUT = WR_CE ? WR_DI : scrub_q;

  assign DO         = do_q;
  assign ERR_SINGLE = err_single_q;
  assign ERR_MULTI  = err_multi_q;
  assign HARD_FAULT = hard_fault_q;
  assign FAULT_MASK = fault_mask_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// Bench for tmr_scrub_ctrl with a model replica bank.
// Directed scenarios plus randomized single-upset rounds.
module tb_tmr_scrub_ctrl;

  localparam int W     = 32;
  localparam int CNT_W = 2;
  localparam int PERS  = 3;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic         EN;
  logic         WR_CE;
  logic [W-1:0] WR_DI;
  logic         CLR;
  logic [2:0]   CE_OUT;
  logic [W-1:0] DI_OUT;
  logic [W-1:0] DO;
  logic         ERR_SINGLE;
  logic         ERR_MULTI;
  logic         HARD_FAULT;
  logic [2:0]   FAULT_MASK;
  logic [CNT_W-1:0] ERR_CNT;

  logic [W-1:0] rep [3];
  logic [2:0]   inj_m;
  logic [W-1:0] inj_v [3];
  logic [2:0]   stuck;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  tmr_scrub_ctrl #(.W(W), .CNT_W(CNT_W), .PERSIST(PERS)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .EN         (EN),
    .WR_CE      (WR_CE),
    .WR_DI      (WR_DI),
    .A          (rep[0]),
    .B          (rep[1]),
    .C          (rep[2]),
    .CLR        (CLR),
    .CE_OUT     (CE_OUT),
    .DI_OUT     (DI_OUT),
    .DO         (DO),
    .ERR_SINGLE (ERR_SINGLE),
    .ERR_MULTI  (ERR_MULTI),
    .HARD_FAULT (HARD_FAULT),
    .FAULT_MASK (FAULT_MASK),
    .ERR_CNT    (ERR_CNT)
  );

  // Replica bank: injected upsets, stuck cells, else CE capture.
  always @(posedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (inj_m[i])       rep[i] <= inj_v[i];
      else if (stuck[i])  rep[i] <= '0;
      else if (CE_OUT[i]) rep[i] <= DI_OUT;
    end
  end

  function automatic logic [W-1:0] maj(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [W-1:0] c
  );
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) begin
      int n;
      n = int'(a[k]) + int'(b[k]) + int'(c[k]);
      r[k] = (n >= 2);
    end
    return r;
  endfunction

  task automatic chk(
    input string tag, input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [W-1:0] data;
    int           idx;
    int           bitn;
    int           exp_cnt;
    RSTN  = 1'b0;
    EN    = 1'b1;
    WR_CE = 1'b0;
    WR_DI = '0;
    CLR   = 1'b0;
    inj_m = 3'b000;
    stuck = 3'b000;
    for (int i = 0; i < 3; i++) inj_v[i] = '0;
    #3;
    chk("rst_do", DO, 0);
    chk("rst_cnt", 32'(ERR_CNT), 0);
    chk("rst_hf", 32'(HARD_FAULT), 0);
    chk("rst_ce", 32'(CE_OUT), 0);
    chk("rst_di", DI_OUT, 0);
    #4;
    RSTN = 1'b1;

    // Load all replicas via a functional write.
    WR_CE = 1'b1;
    WR_DI = 32'h1234_5678;
    #1;
    chk("wr_ce", 32'(CE_OUT), 32'h7);
    chk("wr_di", DI_OUT, 32'h1234_5678);
    step();
    WR_CE = 1'b0;
    step();
    chk("clean_do", DO, 32'h1234_5678);
    chk("clean_es", 32'(ERR_SINGLE), 0);
    chk("clean_ce", 32'(CE_OUT), 0);
    chk("clean_cnt", 32'(ERR_CNT), 0);

    // Single-bit upset on replica 1.
    inj_m = 3'b010;
    inj_v[1] = 32'h1234_5679;
    step();
    inj_m = 3'b000;
    step();
    chk("s_es", 32'(ERR_SINGLE), 1);
    chk("s_ce", 32'(CE_OUT), 32'h2);
    chk("s_di", DI_OUT, 32'h1234_5678);
    chk("s_cnt", 32'(ERR_CNT), 1);
    step();
    chk("s_es_off", 32'(ERR_SINGLE), 0);
    chk("s_ce_off", 32'(CE_OUT), 0);
    chk("s_rep", rep[1], 32'h1234_5678);
    step();
    chk("s_idle_ce", 32'(CE_OUT), 0);
    chk("s_cnt2", 32'(ERR_CNT), 1);

    // Replica 2 stuck at zero: PERSIST rounds then fault.
    stuck = 3'b100;
    step();
    for (int r = 0; r < PERS; r++) begin
      step();
      chk("stk_ce_scrub", 32'(CE_OUT), 32'h4);
      step();
      chk("stk_ce_check", 32'(CE_OUT), 0);
      if (r < PERS - 1) chk("stk_hf_early", 32'(HARD_FAULT), 0);
    end
    step();
    chk("stk_hf", 32'(HARD_FAULT), 1);
    chk("stk_fm", 32'(FAULT_MASK), 32'h4);
    chk("stk_cnt", 32'(ERR_CNT), 2);
    chk("stk_ce_fault", 32'(CE_OUT), 0);
    stuck = 3'b000;
    CLR   = 1'b1;
    WR_CE = 1'b1;
    WR_DI = 32'h1234_5678;
    step();
    CLR   = 1'b0;
    WR_CE = 1'b0;
    chk("clr_hf", 32'(HARD_FAULT), 0);
    chk("clr_fm", 32'(FAULT_MASK), 0);
    chk("clr_cnt", 32'(ERR_CNT), 0);
    step();
    chk("clr_ce", 32'(CE_OUT), 0);
    chk("clr_es", 32'(ERR_SINGLE), 0);

    // Three-way disagreement goes straight to fault.
    inj_m = 3'b111;
    inj_v[0] = 32'h1;
    inj_v[1] = 32'h2;
    inj_v[2] = 32'h4;
    step();
    inj_m = 3'b000;
    chk("m_ce0", 32'(CE_OUT), 0);
    step();
    chk("m_em", 32'(ERR_MULTI), 1);
    chk("m_es", 32'(ERR_SINGLE), 0);
    chk("m_hf", 32'(HARD_FAULT), 1);
    chk("m_fm", 32'(FAULT_MASK), 32'h7);
    chk("m_cnt", 32'(ERR_CNT), 1);
    chk("m_do", DO, 0);
    chk("m_ce1", 32'(CE_OUT), 0);
    step();
    chk("m_em_off", 32'(ERR_MULTI), 0);
    chk("m_ce2", 32'(CE_OUT), 0);
    CLR   = 1'b1;
    WR_CE = 1'b1;
    WR_DI = 32'h1234_5678;
    step();
    CLR   = 1'b0;
    WR_CE = 1'b0;
    chk("m_clr_hf", 32'(HARD_FAULT), 0);
    step();

    // Functional write during SCRUB wins.
    inj_m = 3'b001;
    inj_v[0] = 32'h1234_5670;
    step();
    inj_m = 3'b000;
    step();
    chk("w_es", 32'(ERR_SINGLE), 1);
    chk("w_ce_scrub", 32'(CE_OUT), 32'h1);
    WR_CE = 1'b1;
    WR_DI = 32'hDEAD_BEEF;
    #1;
    chk("w_ce", 32'(CE_OUT), 32'h7);
    chk("w_di", DI_OUT, 32'hDEAD_BEEF);
    step();
    WR_CE = 1'b0;
    #1;
    chk("w_es_off", 32'(ERR_SINGLE), 0);
    chk("w_ce_idle", 32'(CE_OUT), 0);
    step();
    chk("w_do", DO, 32'hDEAD_BEEF);
    chk("w_ce_idle2", 32'(CE_OUT), 0);
    chk("w_es_off2", 32'(ERR_SINGLE), 0);
    chk("w_cnt", 32'(ERR_CNT), 1);
    exp_cnt = 1;

    // Random single upsets; counter saturates.
    for (int it = 0; it < 6; it++) begin
      data  = $urandom;
      WR_CE = 1'b1;
      WR_DI = data;
      step();
      WR_CE = 1'b0;
      step();
      chk("r_do", DO, data);
      idx  = $urandom_range(0, 2);
      bitn = $urandom_range(0, W - 1);
      inj_m = 3'(1 << idx);
      inj_v[idx] = data ^ (32'h1 << bitn);
      step();
      inj_m = 3'b000;
      step();
      exp_cnt = (exp_cnt + 1 > 3) ? 3 : exp_cnt + 1;
      chk("r_es", 32'(ERR_SINGLE), 1);
      chk("r_ce", 32'(CE_OUT), 32'(1 << idx));
      chk("r_di", DI_OUT, data);
      chk("r_cnt", 32'(ERR_CNT), 32'(exp_cnt));
      step();
      step();
      chk("r_rep", rep[idx], data);
      chk("r_maj", maj(rep[0], rep[1], rep[2]), data);
      chk("r_do2", DO, data);
      chk("r_ce_idle", 32'(CE_OUT), 0);
      chk("r_hf", 32'(HARD_FAULT), 0);
    end

    // Asynchronous reset in the middle of CHECK.
    data = 32'hA5A5_0F0F;
    WR_CE = 1'b1;
    WR_DI = data;
    step();
    WR_CE = 1'b0;
    step();
    inj_m = 3'b010;
    inj_v[1] = data ^ 32'h100;
    step();
    inj_m = 3'b000;
    step();
    step();
    #2;
    RSTN = 1'b0;
    #1;
    chk("ar_do", DO, 0);
    chk("ar_cnt", 32'(ERR_CNT), 0);
    chk("ar_es", 32'(ERR_SINGLE), 0);
    chk("ar_hf", 32'(HARD_FAULT), 0);
    chk("ar_fm", 32'(FAULT_MASK), 0);
    chk("ar_ce", 32'(CE_OUT), 0);
    chk("ar_di", DI_OUT, 0);
    #1;
    RSTN = 1'b1;
    step();

    // Asynchronous reset in the middle of SCRUB drops CE.
    inj_m = 3'b100;
    inj_v[2] = data ^ 32'h1;
    step();
    inj_m = 3'b000;
    step();
    chk("as_ce_scrub", 32'(CE_OUT), 32'h4);
    #2;
    RSTN = 1'b0;
    #1;
    chk("as_ce", 32'(CE_OUT), 0);
    WR_CE = 1'b1;
    WR_DI = 32'h0BAD_F00D;
    #1;
    chk("as_ce_wr", 32'(CE_OUT), 32'h7);
    chk("as_di_wr", DI_OUT, 32'h0BAD_F00D);
    WR_CE = 1'b0;
    RSTN  = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
